// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: round-robin sharing of the DDR burst user interface
// between two write ports (w0, w1) and two read ports (r0, r1).
// Port index order for arbitration: w0=0, r0=1, w1=2, r1=3 (bit 0 set = read).
module ddr_burst_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  ui_clk,
    input  logic                  rst_n,
    input  logic                  init_calib_complete,
    // write port 0
    input  logic                  w0_req,
    input  logic [LEN_WIDTH-1:0]  w0_len,
    input  logic [ADDR_WIDTH-1:0] w0_addr,
    input  logic [DATA_WIDTH-1:0] w0_data,
    output logic                  w0_data_req,
    output logic                  w0_grant,
    output logic                  w0_finish,
    // write port 1
    input  logic                  w1_req,
    input  logic [LEN_WIDTH-1:0]  w1_len,
    input  logic [ADDR_WIDTH-1:0] w1_addr,
    input  logic [DATA_WIDTH-1:0] w1_data,
    output logic                  w1_data_req,
    output logic                  w1_grant,
    output logic                  w1_finish,
    // read port 0
    input  logic                  r0_req,
    input  logic [LEN_WIDTH-1:0]  r0_len,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    output logic [DATA_WIDTH-1:0] r0_data,
    output logic                  r0_data_valid,
    output logic                  r0_grant,
    output logic                  r0_finish,
    // read port 1
    input  logic                  r1_req,
    input  logic [LEN_WIDTH-1:0]  r1_len,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    output logic [DATA_WIDTH-1:0] r1_data,
    output logic                  r1_data_valid,
    output logic                  r1_grant,
    output logic                  r1_finish,
    output logic                  abort,
    // downstream burst engine
    output logic                  rd_burst_req,
    output logic [LEN_WIDTH-1:0]  rd_burst_len,
    output logic [ADDR_WIDTH-1:0] rd_burst_addr,
    input  logic                  rd_burst_data_valid,
    input  logic [DATA_WIDTH-1:0] rd_burst_data,
    input  logic                  rd_burst_finish,
    output logic                  wr_burst_req,
    output logic [LEN_WIDTH-1:0]  wr_burst_len,
    output logic [ADDR_WIDTH-1:0] wr_burst_addr,
    input  logic                  wr_burst_data_req,
    output logic [DATA_WIDTH-1:0] wr_burst_data,
    input  logic                  wr_burst_finish
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RELEASE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            win_q, win_d;
    logic [1:0]            last_q, last_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            grant_q, grant_d;
    logic [3:0]            finish_q, finish_d;
    logic                  abort_q, abort_d;
    logic                  rd_req_q, rd_req_d;
    logic                  wr_req_q, wr_req_d;

    logic [3:0]            req_vec;
    logic [1:0]            rr_idx;
    logic [1:0]            cand;
    logic                  cand_vld;
    logic [LEN_WIDTH-1:0]  cand_len;
    logic [ADDR_WIDTH-1:0] cand_addr;
    logic                  busy;
    logic                  win_done;

    assign req_vec = {r1_req, w1_req, r0_req, w0_req};

    // Round-robin search: first requester after the last served index.
    always_comb begin
        cand     = 2'd0;
        cand_vld = 1'b0;
        rr_idx   = 2'd0;
        for (int off = 1; off <= 4; off++) begin
            rr_idx = last_q + 2'(off);
            if (!cand_vld && req_vec[rr_idx]) begin
                cand     = rr_idx;
                cand_vld = 1'b1;
            end
        end
    end

    // Select the candidate's burst descriptor.
    always_comb begin
        case (cand)
            2'd0:    begin cand_len = w0_len; cand_addr = w0_addr; end
            2'd1:    begin cand_len = r0_len; cand_addr = r0_addr; end
            2'd2:    begin cand_len = w1_len; cand_addr = w1_addr; end
            default: begin cand_len = r1_len; cand_addr = r1_addr; end
        endcase
    end

    // Completion only counts when it matches the winner's direction.
    assign win_done = win_q[0] ? rd_burst_finish : wr_burst_finish;

    // Next-state logic for the grant FSM and all registered outputs.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        len_d    = len_q;
        addr_d   = addr_q;
        grant_d  = grant_q;
        finish_d = 4'b0000;
        abort_d  = 1'b0;
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_calib_complete && cand_vld) begin
                    win_d    = cand;
                    len_d    = cand_len;
                    addr_d   = cand_addr;
                    grant_d  = 4'b0001 << cand;
                    // Request goes out in the ISSUE cycle; zero-length never reaches the engine.
                    rd_req_d = cand[0] && (cand_len != '0);
                    wr_req_d = !cand[0] && (cand_len != '0);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (!init_calib_complete) begin
                    abort_d = 1'b1;
                    grant_d = 4'b0000;
                    last_d  = win_q;
                    state_d = IDLE;
                end else if (len_q == '0) begin
                    finish_d = 4'b0001 << win_q;
                    state_d  = RELEASE;
                end else begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!init_calib_complete) begin
                    abort_d = 1'b1;
                    grant_d = 4'b0000;
                    last_d  = win_q;
                    state_d = IDLE;
                end else if (win_done) begin
                    finish_d = 4'b0001 << win_q;
                    state_d  = RELEASE;
                end
            end
            default: begin
                last_d  = win_q;
                grant_d = 4'b0000;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            win_q    <= 2'd0;
            last_q   <= 2'd3;
            len_q    <= '0;
            addr_q   <= '0;
            grant_q  <= 4'b0000;
            finish_q <= 4'b0000;
            abort_q  <= 1'b0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            grant_q  <= grant_d;
            finish_q <= finish_d;
            abort_q  <= abort_d;
            rd_req_q <= rd_req_d;
            wr_req_q <= wr_req_d;
        end
    end

    assign {r1_grant, w1_grant, r0_grant, w0_grant}     = grant_q;
    assign {r1_finish, w1_finish, r0_finish, w0_finish} = finish_q;
    assign abort         = abort_q;
    assign rd_burst_req  = rd_req_q;
    assign rd_burst_len  = len_q;
    assign rd_burst_addr = addr_q;
    assign wr_burst_req  = wr_req_q;
    assign wr_burst_len  = len_q;
    assign wr_burst_addr = addr_q;

    assign busy          = (state_q == BUSY);
    assign w0_data_req   = wr_burst_data_req & busy & grant_q[0];
    assign w1_data_req   = wr_burst_data_req & busy & grant_q[2];
    assign r0_data_valid = rd_burst_data_valid & busy & grant_q[1];
    assign r1_data_valid = rd_burst_data_valid & busy & grant_q[3];
    assign r0_data       = rd_burst_data;
    assign r1_data       = rd_burst_data;

    // Write data mux keyed on grant alone: the last beat arrives the cycle
    // after the final data strobe and must still reach the engine.
    always_comb begin
        wr_burst_data = '0;
        if (grant_q[0])      wr_burst_data = w0_data;
        else if (grant_q[2]) wr_burst_data = w1_data;
    end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Testbench for ddr_burst_arbiter: directed scenarios plus a randomized
// run checked against a round-robin reference model.
module tb_ddr_burst_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int LW = 10;

    logic ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    logic          rst_n, calib;
    logic [3:0]    req;
    logic [LW-1:0] plen  [4];
    logic [AW-1:0] paddr [4];
    logic [DW-1:0] w0_data, w1_data;

    logic w0_data_req, w0_grant, w0_finish, w1_data_req, w1_grant, w1_finish;
    logic r0_data_valid, r0_grant, r0_finish, r1_data_valid, r1_grant, r1_finish;
    logic [DW-1:0] r0_data, r1_data;
    logic abort;
    logic rd_burst_req, wr_burst_req;
    logic [LW-1:0] rd_burst_len, wr_burst_len;
    logic [AW-1:0] rd_burst_addr, wr_burst_addr;
    logic rd_burst_data_valid, rd_burst_finish, wr_burst_data_req, wr_burst_finish;
    logic [DW-1:0] rd_burst_data, wr_burst_data;

    logic [3:0] gnt, fin, dvec;
    assign gnt  = {r1_grant, w1_grant, r0_grant, w0_grant};
    assign fin  = {r1_finish, w1_finish, r0_finish, w0_finish};
    assign dvec = {r1_data_valid, w1_data_req, r0_data_valid, w0_data_req};

    ddr_burst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .ui_clk(ui_clk), .rst_n(rst_n), .init_calib_complete(calib),
        .w0_req(req[0]), .w0_len(plen[0]), .w0_addr(paddr[0]), .w0_data(w0_data),
        .w0_data_req(w0_data_req), .w0_grant(w0_grant), .w0_finish(w0_finish),
        .w1_req(req[2]), .w1_len(plen[2]), .w1_addr(paddr[2]), .w1_data(w1_data),
        .w1_data_req(w1_data_req), .w1_grant(w1_grant), .w1_finish(w1_finish),
        .r0_req(req[1]), .r0_len(plen[1]), .r0_addr(paddr[1]), .r0_data(r0_data),
        .r0_data_valid(r0_data_valid), .r0_grant(r0_grant), .r0_finish(r0_finish),
        .r1_req(req[3]), .r1_len(plen[3]), .r1_addr(paddr[3]), .r1_data(r1_data),
        .r1_data_valid(r1_data_valid), .r1_grant(r1_grant), .r1_finish(r1_finish),
        .abort(abort),
        .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
        .rd_burst_finish(rd_burst_finish),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
        .wr_burst_finish(wr_burst_finish)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int m_last = 3;
    bit eng_hold = 1'b0;

    // Behavioural burst engine: accepts a request, delivers len strobes with
    // random gaps, then pulses finish. Drops everything on reset or abort.
    initial begin
        bit eng_busy, eng_rd;
        int eng_cnt;
        eng_busy = 0; eng_rd = 0; eng_cnt = 0;
        rd_burst_data_valid = 0; rd_burst_data = '0; rd_burst_finish = 0;
        wr_burst_data_req = 0; wr_burst_finish = 0;
        forever begin
            @(negedge ui_clk);
            rd_burst_data_valid = 0; wr_burst_data_req = 0;
            rd_burst_finish = 0; wr_burst_finish = 0;
            if (!rst_n || abort) eng_busy = 0;
            else if (!eng_busy) begin
                if (rd_burst_req) begin eng_busy = 1; eng_rd = 1; eng_cnt = int'(rd_burst_len); end
                else if (wr_burst_req) begin eng_busy = 1; eng_rd = 0; eng_cnt = int'(wr_burst_len); end
            end else if (!eng_hold) begin
                if (eng_cnt > 0) begin
                    if ($urandom_range(0, 2) != 0) begin
                        if (eng_rd) begin
                            rd_burst_data_valid = 1;
                            rd_burst_data = {$urandom, $urandom, $urandom, $urandom};
                        end else wr_burst_data_req = 1;
                        eng_cnt--;
                    end
                end else begin
                    if (eng_rd) rd_burst_finish = 1; else wr_burst_finish = 1;
                    eng_busy = 0;
                end
            end
        end
    end

    // Reference round-robin: first requester after last, order w0,r0,w1,r1.
    function automatic int rr(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic tick();
        w0_data = {$urandom, $urandom, $urandom, $urandom};
        w1_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge ui_clk); #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 0; req = '0; eng_hold = 0; calib = 1;
        repeat (3) tick();
        rst_n = 1; m_last = 3;
    endtask

    task automatic test_reset();
        rst_n = 0; req = '0; calib = 1;
        for (int p = 0; p < 4; p++) begin plen[p] = '0; paddr[p] = '0; end
        repeat (2) tick();
        checks++; if (gnt !== 4'b0 || fin !== 4'b0 || abort !== 1'b0) begin errors++;
            $display("FAIL reset_ctl: gnt=%b fin=%b abort=%b want 0", gnt, fin, abort); end
        checks++; if (rd_burst_req !== 1'b0 || wr_burst_req !== 1'b0 || rd_burst_len !== '0 || wr_burst_addr !== '0) begin errors++;
            $display("FAIL reset_ds: rreq=%b wreq=%b len=%0d addr=%0h want 0", rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_addr); end
        rst_n = 1; m_last = 3;
        tick();
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_idle: gnt=%b want 0", gnt); end
    endtask

    task automatic test_single_write();
        int nreq, ndr, fcyc; bit done;
        do_reset();
        plen[0] = 10'd4; paddr[0] = 28'h100; req = 4'b0001;
        tick();
        checks++; if (wr_burst_req !== 1'b1 || wr_burst_len !== 10'd4 || wr_burst_addr !== 28'h100) begin errors++;
            $display("FAIL single_issue: req=%b len=%0d addr=%0h want 1/4/100", wr_burst_req, wr_burst_len, wr_burst_addr); end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_grant: gnt=%b want 0001", gnt); end
        nreq = 1; ndr = 0; fcyc = -10; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            checks++; if (wr_burst_data !== w0_data) begin errors++;
                $display("FAIL single_wdata: got %0h want %0h", wr_burst_data, w0_data); end
            if (wr_burst_req) nreq++;
            if (w0_data_req) ndr++;
            if (wr_burst_finish) fcyc = cyc;
            if (w0_finish) begin
                done = 1; req = '0;
                checks++; if (cyc != fcyc + 1) begin errors++;
                    $display("FAIL single_fin_lat: finish at %0d want %0d", cyc, fcyc + 1); end
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL single_timeout: no w0_finish got 0 want 1"); end
        checks++; if (nreq != 1) begin errors++; $display("FAIL single_reqcnt: got %0d want 1", nreq); end
        checks++; if (ndr != 4) begin errors++; $display("FAIL single_datareq: got %0d want 4", ndr); end
        tick();
        checks++; if (gnt !== 4'b0 || w0_finish !== 1'b0) begin errors++;
            $display("FAIL single_release: gnt=%b fin=%b want 0/0", gnt, w0_finish); end
        checks++; if (wr_burst_data !== '0) begin errors++; $display("FAIL single_wdata_idle: got %0h want 0", wr_burst_data); end
    endtask

    task automatic test_round_robin();
        int order [5];
        int k, lastf;
        logic [3:0] prev_g;
        order = '{0, 1, 2, 3, 0};
        do_reset();
        for (int p = 0; p < 4; p++) begin plen[p] = 10'd2; paddr[p] = AW'(p * 64); end
        req = 4'hF; k = 0; lastf = -100; prev_g = '0;
        for (int i = 0; i < 300 && k < 5; i++) begin
            tick();
            if (rd_burst_finish || wr_burst_finish) lastf = cyc;
            if ((rd_burst_req || wr_burst_req) && k > 0) begin
                checks++; if (cyc - lastf != 3) begin errors++;
                    $display("FAIL rr_gap: req %0d cycles after finish want 3", cyc - lastf); end
            end
            if (gnt != 4'b0 && prev_g == 4'b0) begin
                checks++; if (gnt !== (4'b0001 << order[k])) begin errors++;
                    $display("FAIL rr_order[%0d]: gnt=%b want %b", k, gnt, 4'b0001 << order[k]); end
                k++;
            end
            prev_g = gnt;
            req = 4'hF & ~fin;
        end
        checks++; if (k < 5) begin errors++; $display("FAIL rr_timeout: grants %0d want 5", k); end
    endtask

    task automatic test_no_preempt();
        int nv; bit done;
        do_reset();
        plen[3] = 10'd6; paddr[3] = 28'h3000; plen[0] = 10'd1; paddr[0] = 28'h10;
        req = 4'b1000; nv = 0; done = 0;
        for (int i = 1; i < 80 && !done; i++) begin
            tick();
            if (i == 3) req[0] = 1'b1;
            checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL np_grant: gnt=%b want 1000", gnt); end
            checks++; if (r0_data_valid !== 1'b0 || r1_data_valid !== rd_burst_data_valid || r1_data !== rd_burst_data) begin errors++;
                $display("FAIL np_route: r0v=%b r1v=%b want 0/%b", r0_data_valid, r1_data_valid, rd_burst_data_valid); end
            if (r1_data_valid) nv++;
            if (r1_finish) begin done = 1; req[3] = 1'b0; end
        end
        checks++; if (!done || nv != 6) begin errors++; $display("FAIL np_beats: done=%b beats=%0d want 1/6", done, nv); end
        repeat (2) tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL np_next: gnt=%b want 0001", gnt); end
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (w0_finish) begin done = 1; req = '0; end
        end
        checks++; if (!done) begin errors++; $display("FAIL np_w0_timeout: no finish got 0 want 1"); end
    endtask

    task automatic test_zero_len();
        do_reset();
        plen[1] = 10'd0; paddr[1] = 28'h55; req = 4'b0010;
        tick();
        checks++; if (gnt !== 4'b0010 || rd_burst_req !== 1'b0 || r0_finish !== 1'b0) begin errors++;
            $display("FAIL zl_issue: gnt=%b rreq=%b fin=%b want 0010/0/0", gnt, rd_burst_req, r0_finish); end
        tick();
        checks++; if (r0_finish !== 1'b1 || rd_burst_req !== 1'b0 || wr_burst_req !== 1'b0) begin errors++;
            $display("FAIL zl_finish: fin=%b rreq=%b wreq=%b want 1/0/0", r0_finish, rd_burst_req, wr_burst_req); end
        req = '0;
        tick();
        checks++; if (r0_finish !== 1'b0 || gnt !== 4'b0) begin errors++;
            $display("FAIL zl_after: fin=%b gnt=%b want 0/0", r0_finish, gnt); end
    endtask

    task automatic test_calib();
        do_reset();
        calib = 0; eng_hold = 1;
        plen[2] = 10'd3; paddr[2] = 28'h2200; req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL cal_nogrant: gnt=%b want 0", gnt); end
        end
        calib = 1;
        tick();
        checks++; if (gnt !== 4'b0100 || wr_burst_req !== 1'b1 || wr_burst_len !== 10'd3) begin errors++;
            $display("FAIL cal_grant: gnt=%b wreq=%b len=%0d want 0100/1/3", gnt, wr_burst_req, wr_burst_len); end
        tick();
        checks++; if (gnt !== 4'b0100 || abort !== 1'b0) begin errors++;
            $display("FAIL cal_busy: gnt=%b abort=%b want 0100/0", gnt, abort); end
        calib = 0;
        tick();
        checks++; if (abort !== 1'b1 || gnt !== 4'b0 || w1_finish !== 1'b0) begin errors++;
            $display("FAIL cal_abort: abort=%b gnt=%b fin=%b want 1/0/0", abort, gnt, w1_finish); end
        req = '0;
        tick();
        checks++; if (abort !== 1'b0 || w1_finish !== 1'b0) begin errors++;
            $display("FAIL cal_after: abort=%b fin=%b want 0/0", abort, w1_finish); end
        calib = 1; eng_hold = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        eng_hold = 1; plen[3] = 10'd8; paddr[3] = 28'h7770; req = 4'b1000;
        tick();
        checks++; if (rd_burst_req !== 1'b1 || gnt !== 4'b1000 || rd_burst_len !== 10'd8) begin errors++;
            $display("FAIL rm_issue: rreq=%b gnt=%b len=%0d want 1/1000/8", rd_burst_req, gnt, rd_burst_len); end
        tick();
        rst_n = 0; req = 4'hF;
        for (int p = 0; p < 4; p++) plen[p] = 10'd1;
        tick();
        checks++; if (gnt !== 4'b0 || fin !== 4'b0 || abort !== 1'b0 || rd_burst_req !== 1'b0 || wr_burst_req !== 1'b0) begin errors++;
            $display("FAIL rm_ctl: gnt=%b fin=%b abort=%b want all 0", gnt, fin, abort); end
        checks++; if (rd_burst_len !== '0 || rd_burst_addr !== '0 || r1_data_valid !== 1'b0) begin errors++;
            $display("FAIL rm_ds: len=%0d addr=%0h dv=%b want 0", rd_burst_len, rd_burst_addr, r1_data_valid); end
        rst_n = 1; eng_hold = 0;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rm_first: gnt=%b want 0001", gnt); end
        do_reset();
    endtask

    task automatic test_random();
        int cur, exp, cnt, dropped;
        logic [3:0] req_prev, cur_mask;
        logic [DW-1:0] exp_wd;
        do_reset();
        cur = -1; cnt = 0; req_prev = '0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            dropped = -1;
            checks++; if ($countones(gnt) > 1 || (rd_burst_req && wr_burst_req)) begin errors++;
                $display("FAIL rnd_exclusive: gnt=%b rreq=%b wreq=%b", gnt, rd_burst_req, wr_burst_req); end
            if (gnt != 4'b0 && cur < 0) begin
                exp = rr(m_last, req_prev);
                checks++; if (exp < 0 || gnt !== (4'b0001 << exp)) begin errors++;
                    $display("FAIL rnd_grant: gnt=%b want port %0d (last=%0d req=%b)", gnt, exp, m_last, req_prev); end
                cur = (exp < 0) ? 0 : exp; cnt = 0;
            end
            cur_mask = (cur < 0) ? 4'b0 : (4'b0001 << cur);
            if (rd_burst_req || wr_burst_req) begin
                checks++;
                if (cur < 0 || plen[cur] == '0 || rd_burst_req !== (cur % 2 == 1) ||
                    (rd_burst_req && (rd_burst_len !== plen[cur] || rd_burst_addr !== paddr[cur])) ||
                    (wr_burst_req && (wr_burst_len !== plen[cur] || wr_burst_addr !== paddr[cur]))) begin errors++;
                    $display("FAIL rnd_issue: port=%0d rreq=%b len=%0d/%0d", cur, rd_burst_req, rd_burst_len, wr_burst_len); end
            end
            checks++; if ((dvec & ~cur_mask) !== 4'b0 || r0_data !== rd_burst_data || r1_data !== rd_burst_data) begin errors++;
                $display("FAIL rnd_route: strobes=%b owner=%b", dvec, cur_mask); end
            exp_wd = (cur == 0) ? w0_data : (cur == 2) ? w1_data : '0;
            checks++; if (wr_burst_data !== exp_wd) begin errors++;
                $display("FAIL rnd_wdata: got %0h want %0h", wr_burst_data, exp_wd); end
            if ((dvec & cur_mask) != 4'b0) cnt++;
            if (fin != 4'b0) begin
                checks++; if (fin !== cur_mask || cur < 0 || cnt != int'(plen[cur])) begin errors++;
                    $display("FAIL rnd_finish: fin=%b owner=%b beats=%0d", fin, cur_mask, cnt); end
                if (cur >= 0) begin m_last = cur; req[cur] = 1'b0; dropped = cur; end
                cur = -1;
            end
            for (int p = 0; p < 4; p++) begin
                if (!req[p] && p != dropped && $urandom_range(0, 3) == 0) begin
                    plen[p] = LW'($urandom_range(0, 5)); paddr[p] = AW'($urandom); req[p] = 1'b1;
                end
            end
            req_prev = req;
        end
    endtask

    initial begin
        rst_n = 0; calib = 1; req = '0;
        w0_data = '0; w1_data = '0;
        for (int p = 0; p < 4; p++) begin plen[p] = '0; paddr[p] = '0; end
        test_reset();
        test_single_write();
        test_round_robin();
        test_no_preempt();
        test_zero_len();
        test_calib();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
